yutorina_bus_master_if: RTL and testbench

YUTORINA_BUS_MASTER_IF -- requirements
Module: yutorina_bus_master_if

---
 rtl/yutorina_bus_master_if_pkg.sv | 21 ++
 rtl/yutorina_bus_master_if.sv | 126 ++++++++++++
 tb/tb_yutorina_bus_master_if.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yutorina_bus_master_if_pkg.sv
// Shared bus definitions: active-low levels, bus widths and the
// bus-master interface state encodings.
package yutorina_bus_master_if_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic BUS_RW_READ  = 1'b1;
    localparam logic BUS_RW_WRITE = 1'b0;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_WAIT   = 2'd3
    } bus_if_state_t;

endpackage

// File: rtl/yutorina_bus_master_if.sv
// Bus master interface: arbiter handshake, single-cycle address strobe,
// ready wait with timeout, and a registered completion pulse to the core.
module yutorina_bus_master_if
    import yutorina_bus_master_if_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_req,
    input  logic                   core_rw,
    input  logic [WORD_ADDR_W-1:0] core_addr,
    input  logic [WORD_DATA_W-1:0] core_wr_data,
    output logic [WORD_DATA_W-1:0] core_rd_data,
    output logic                   core_busy,
    output logic                   core_done,
    output logic                   core_err,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_DATA_W-1:0] bus_wr_data,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy_
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    bus_if_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rw_q, rw_d;
    logic [WORD_ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d;
    logic [WORD_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   on_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BUS_IF_STATE_IDLE;
            cnt_q     <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            BUS_IF_STATE_IDLE: begin
                if (core_req) begin
                    rw_d    = core_rw;
                    addr_d  = core_addr;
                    wdata_d = core_wr_data;
                    state_d = BUS_IF_STATE_REQ;
                end
            end
            BUS_IF_STATE_REQ: begin
                if (bus_grnt_ == ENABLE_) begin
                    cnt_d   = '0;
                    state_d = BUS_IF_STATE_ACCESS;
                end
            end
            BUS_IF_STATE_ACCESS,
            BUS_IF_STATE_WAIT: begin
                // Ready is checked first so it wins over a same-cycle timeout.
                if (bus_rdy_ == ENABLE_) begin
                    if (rw_q == BUS_RW_READ) begin
                        rd_data_d = bus_rd_data;
                    end
                    done_d  = 1'b1;
                    state_d = BUS_IF_STATE_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = BUS_IF_STATE_IDLE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = BUS_IF_STATE_WAIT;
                end
            end
            default: begin
                state_d = BUS_IF_STATE_IDLE;
            end
        endcase
    end

    assign on_bus = (state_q == BUS_IF_STATE_ACCESS) ||
                    (state_q == BUS_IF_STATE_WAIT);

    assign core_rd_data = rd_data_q;
    assign core_busy    = (state_q != BUS_IF_STATE_IDLE);
    assign core_done    = done_q;
    assign core_err     = err_q;

    // The done cycle is spent in IDLE, which gives the arbiter its gap.
    assign bus_req_    = (state_q == BUS_IF_STATE_IDLE) ? DISABLE_ : ENABLE_;
    assign bus_as_     = (state_q == BUS_IF_STATE_ACCESS) ? ENABLE_ : DISABLE_;
    assign bus_addr    = on_bus ? addr_q : '0;
    assign bus_rw      = on_bus ? rw_q : 1'b0;
    assign bus_wr_data = on_bus ? wdata_q : '0;

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Bench for yutorina_bus_master_if: table vectors, random transfers
// against a timeline model, and hand-written reset/back-to-back cases.
module tb_yutorina_bus_master_if;
    import yutorina_bus_master_if_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_rw;
    logic [29:0] core_addr;
    logic [31:0] core_wr_data;
    logic [31:0] core_rd_data;
    logic        core_busy;
    logic        core_done;
    logic        core_err;
    logic        bus_req_;
    logic        bus_grnt_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    always #5 clk = ~clk;

    yutorina_bus_master_if #(.TIMEOUT(TO)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .core_rw      (core_rw),
        .core_addr    (core_addr),
        .core_wr_data (core_wr_data),
        .core_rd_data (core_rd_data),
        .core_busy    (core_busy),
        .core_done    (core_done),
        .core_err     (core_err),
        .bus_req_     (bus_req_),
        .bus_grnt_    (bus_grnt_),
        .bus_addr     (bus_addr),
        .bus_as_      (bus_as_),
        .bus_rw       (bus_rw),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .bus_rdy_     (bus_rdy_)
    );

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          gd;
        int          w;
        logic        to;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd;
    vec_t        tbl[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic scramble_core();
        core_req     = 1'($urandom);
        core_rw      = 1'($urandom);
        core_addr    = 30'($urandom);
        core_wr_data = $urandom;
    endtask

    task automatic run_txn(input vec_t v);
        int c;
        int lat_meas;
        int nwait;
        lat_meas = -1;
        nwait    = v.to ? TO : v.w;
        c        = 0;
        chk1("idle_busy", core_busy, 1'b0);
        chk1("idle_bus_req", bus_req_, 1'b1);
        core_req     = 1'b1;
        core_rw      = v.rw;
        core_addr    = v.addr;
        core_wr_data = v.wdata;
        bus_grnt_    = 1'b1;
        bus_rdy_     = 1'b1;
        bus_rd_data  = $urandom;
        for (int i = 0; i <= v.gd; i++) begin
            @(negedge clk);
            c++;
            if (core_done && lat_meas < 0) lat_meas = c;
            chk1("req_bus_req", bus_req_, 1'b0);
            chk1("req_as", bus_as_, 1'b1);
            chk32("req_addr", {2'b0, bus_addr}, 32'h0);
            chk1("req_busy", core_busy, 1'b1);
            scramble_core();
            bus_grnt_   = (i == v.gd) ? 1'b0 : 1'b1;
            bus_rd_data = $urandom;
        end
        @(negedge clk);
        c++;
        if (core_done && lat_meas < 0) lat_meas = c;
        chk1("acc_as", bus_as_, 1'b0);
        chk1("acc_bus_req", bus_req_, 1'b0);
        chk32("acc_addr", {2'b0, bus_addr}, {2'b0, v.addr});
        chk1("acc_rw", bus_rw, v.rw);
        chk32("acc_wdata", bus_wr_data, v.wdata);
        scramble_core();
        bus_grnt_   = 1'b1;
        bus_rdy_    = (!v.to && nwait == 0) ? 1'b0 : 1'b1;
        bus_rd_data = (bus_rdy_ == 1'b0) ? v.rdata : $urandom;
        for (int j = 1; j <= nwait; j++) begin
            @(negedge clk);
            c++;
            if (core_done && lat_meas < 0) lat_meas = c;
            chk1("wait_as", bus_as_, 1'b1);
            chk1("wait_bus_req", bus_req_, 1'b0);
            chk1("wait_busy", core_busy, 1'b1);
            chk32("wait_addr", {2'b0, bus_addr}, {2'b0, v.addr});
            chk1("wait_rw", bus_rw, v.rw);
            chk32("wait_wdata", bus_wr_data, v.wdata);
            scramble_core();
            bus_rdy_    = (!v.to && j == nwait) ? 1'b0 : 1'b1;
            bus_rd_data = (bus_rdy_ == 1'b0) ? v.rdata : $urandom;
        end
        @(negedge clk);
        c++;
        if (core_done && lat_meas < 0) lat_meas = c;
        core_req = 1'b0;
        bus_rdy_ = 1'b1;
        chk1("done_err", core_err, v.exp_err);
        chk32("done_rd_data", core_rd_data, v.exp_rd);
        chk1("done_bus_req", bus_req_, 1'b1);
        chk1("done_busy", core_busy, 1'b0);
        chk1("done_as", bus_as_, 1'b1);
        chk32("done_addr", {2'b0, bus_addr}, 32'h0);
        @(negedge clk);
        c++;
        if (core_done && lat_meas < 0) lat_meas = c;
        chk1("done_pulse_end", core_done, 1'b0);
        chk1("err_pulse_end", core_err, 1'b0);
        chk32("latency", 32'(lat_meas), 32'(v.lat));
    endtask

    initial begin
        vec_t v;
        logic [31:0] bb_data;

        tbl[0] = '{1'b1, 30'h0000100, 32'h0, 1, 0, 1'b0,
                   32'hDEADBEEF, 4, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{1'b0, 30'h0000004, 32'h12345678, 1, 3, 1'b0,
                   32'h0BADF00D, 7, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 30'h3FFFFFFF, 32'h0, 10, 0, 1'b0,
                   32'hCAFEF00D, 13, 32'hCAFEF00D, 1'b0};
        tbl[3] = '{1'b1, 30'h2AAAAAAA, 32'h0, 0, 0, 1'b1,
                   32'h11111111, 11, 32'hCAFEF00D, 1'b1};
        tbl[4] = '{1'b1, 30'h15555555, 32'h0, 2, 8, 1'b0,
                   32'h55AA55AA, 13, 32'h55AA55AA, 1'b0};
        tbl[5] = '{1'b0, 30'h0000000, 32'hFFFFFFFF, 0, 1, 1'b0,
                   32'h77777777, 4, 32'h55AA55AA, 1'b0};
        tbl[6] = '{1'b1, 30'h0000001, 32'h0, 0, 0, 1'b0,
                   32'h00000000, 3, 32'h00000000, 1'b0};

        rst          = 1'b1;
        core_req     = 1'b1;
        core_rw      = 1'b1;
        core_addr    = 30'h155;
        core_wr_data = 32'hFFFF0000;
        bus_grnt_    = 1'b0;
        bus_rdy_     = 1'b0;
        bus_rd_data  = 32'h12121212;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk32("rst_rd_data", core_rd_data, 32'h0);
        chk1("rst_busy", core_busy, 1'b0);
        chk1("rst_done", core_done, 1'b0);
        chk1("rst_err", core_err, 1'b0);
        chk1("rst_bus_req", bus_req_, 1'b1);
        chk1("rst_as", bus_as_, 1'b1);
        chk32("rst_addr", {2'b0, bus_addr}, 32'h0);
        chk1("rst_rw", bus_rw, 1'b0);
        chk32("rst_wdata", bus_wr_data, 32'h0);
        rst       = 1'b0;
        core_req  = 1'b0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b1;
        model_rd  = 32'h0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_txn(tbl[k]);
            model_rd = tbl[k].exp_rd;
        end

        for (int k = 0; k < 40; k++) begin
            v.rw    = 1'($urandom);
            v.addr  = 30'($urandom);
            v.wdata = $urandom;
            v.gd    = int'($urandom_range(0, 4));
            v.w     = int'($urandom_range(0, TO));
            v.to    = ($urandom_range(0, 5) == 0);
            v.rdata = $urandom;
            v.lat   = v.gd + (v.to ? TO : v.w) + 3;
            v.exp_err = v.to;
            v.exp_rd  = (v.rw && !v.to) ? v.rdata : model_rd;
            run_txn(v);
            model_rd = v.exp_rd;
        end

        // Reset taken while waiting for a slow slave.
        core_req  = 1'b1;
        core_rw   = 1'b1;
        core_addr = 30'h0ABCDEF;
        @(negedge clk);
        core_req  = 1'b0;
        bus_grnt_ = 1'b0;
        @(negedge clk);
        bus_grnt_ = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("rstw_in_wait", bus_as_ == 1'b1 && core_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("rstw_busy", core_busy, 1'b0);
        chk1("rstw_bus_req", bus_req_, 1'b1);
        chk1("rstw_done", core_done, 1'b0);
        chk1("rstw_as", bus_as_, 1'b1);
        chk32("rstw_addr", {2'b0, bus_addr}, 32'h0);
        chk32("rstw_rd_data", core_rd_data, 32'h0);
        model_rd = 32'h0;
        @(negedge clk);
        chk1("rstw_done_after", core_done, 1'b0);
        chk1("rstw_idle_after", core_busy, 1'b0);

        // Request held high with a free bus and zero-wait slave.
        core_req    = 1'b1;
        core_rw     = 1'b1;
        core_addr   = 30'h0000040;
        bus_grnt_   = 1'b0;
        bus_rdy_    = 1'b0;
        bus_rd_data = 32'hB0B00000;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk1("b2b_bus_req", bus_req_, (k % 3 == 0) ? 1'b1 : 1'b0);
            chk1("b2b_done", core_done, (k % 3 == 0) ? 1'b1 : 1'b0);
            chk1("b2b_as", bus_as_, (k % 3 == 2) ? 1'b0 : 1'b1);
            if (k % 3 == 0) begin
                bb_data = 32'hB0B00000 + 32'(k - 1);
                chk32("b2b_rd_data", core_rd_data, bb_data);
            end
            bus_rd_data = 32'hB0B00000 + 32'(k);
        end
        core_req  = 1'b0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b1;
        @(negedge clk);
        chk1("b2b_idle", core_busy, 1'b0);
        chk1("b2b_release", bus_req_, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
